// File: rtl/heap_pq_gen_pkg.sv
// Shared types and helpers for the heap priority queue: FSM states, command decode, heap index math.
package heap_pq_gen_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ENQ_WR,
        ENQ_RDP,
        ENQ_CMP,
        ENQ_SWP2,
        DEQ_RDLAST,
        DEQ_WRROOT,
        RPL_WR,
        HP_RDL,
        HP_RDR,
        HP_CMP,
        HP_SWP2
    } hp_state_e;

    typedef enum logic [1:0] {
        CMD_NOP,
        CMD_ENQ,
        CMD_DEQ,
        CMD_RPL
    } hp_cmd_e;

    function automatic logic better_than(input logic [63:0] a, input logic [63:0] b,
                                         input logic min_first);
        return min_first ? (a < b) : (a > b);
    endfunction

    function automatic logic [31:0] idx_mask(input int aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    function automatic logic [31:0] hp_left(input logic [31:0] i, input int aw);
        return (i << 1) & idx_mask(aw);
    endfunction

    function automatic logic [31:0] hp_right(input logic [31:0] i, input int aw);
        return ((i << 1) | 32'd1) & idx_mask(aw);
    endfunction

    function automatic logic [31:0] hp_parent(input logic [31:0] i, input int aw);
        return (i >> 1) & idx_mask(aw);
    endfunction

    // Enq+deq on an empty queue falls through to a plain insert.
    function automatic hp_cmd_e decode_cmd(input logic enq, input logic deq,
                                           input logic empty, input logic full);
        if (enq && deq && !empty) return CMD_RPL;
        if (enq && !full)         return CMD_ENQ;
        if (deq && !empty)        return CMD_DEQ;
        return CMD_NOP;
    endfunction

endpackage

// File: rtl/heap_pq_gen_mem_swsr.sv
// Single-port RAM with synchronous read: dout reflects the address presented one cycle earlier.
module mem_swsr #(
    parameter int W = 32,
    parameter int D = 16
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [$clog2(D)-1:0] i_addr,
    input  logic [W-1:0]         i_din,
    output logic [W-1:0]         o_dout
);

    logic [W-1:0] r_mem [D];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_din;
        o_dout <= r_mem[i_addr];
    end

endmodule

// File: rtl/heap_pq_gen.sv
// Binary-heap priority queue over one single-port RAM; head held registered on o_kvo_*.
// Optional occupancy statistics (o_count/o_peak) are built when HEAP_PQ_STATS_EN is defined.
//   state      | meaning
//   IDLE       | waiting for a command
//   ENQ_WR     | write new item at size+1, bump size
//   ENQ_RDP    | read parent of current node
//   ENQ_CMP    | child better than parent: move parent down
//   ENQ_SWP2   | write item into parent slot, climb
//   DEQ_RDLAST | read last entry, shrink size
//   DEQ_WRROOT | move last entry to root
//   RPL_WR     | write new item to root
//   HP_RDL     | read left child (or stop at leaf)
//   HP_RDR     | latch left, read right child if present
//   HP_CMP     | pick best child; move it up if better than node
//   HP_SWP2    | write node into child slot, descend
module heap_pq_gen
    import heap_pq_gen_pkg::*;
#(
    parameter int KW        = 16,
    parameter int VW        = 16,
    parameter int DEPTH     = 15,
    parameter bit MIN_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_enq,
    input  logic                         i_deq,
    input  logic [KW-1:0]                i_kvi_key,
    input  logic [VW-1:0]                i_kvi_val,
    output logic [KW-1:0]                o_kvo_key,
    output logic [VW-1:0]                o_kvo_val,
    output logic                         o_kvo_valid,
    output logic                         o_busy,
    output logic                         o_full,
    output logic                         o_empty
`ifdef HEAP_PQ_STATS_EN
   ,output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [$clog2(DEPTH+1)-1:0]   o_peak
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = CW + 1;
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef struct packed {
        logic [KW-1:0] key;
        logic [VW-1:0] val;
    } kv_t;

    function automatic logic better(input kv_t a, input kv_t b);
        return better_than(64'(a.key), 64'(b.key), MIN_FIRST);
    endfunction

    hp_state_e       r_state;
    logic [AW-1:0]   r_size;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   r_cidx;
    kv_t             r_cur;
    kv_t             r_lkv;
    logic            r_rvalid;
    kv_t             r_head;

    kv_t             w_dout;
    kv_t             w_din;
    logic            w_we;
    logic [AW-1:0]   w_ram_idx;
    logic [CW-1:0]   w_addr;
    logic [AW-1:0]   w_left;
    logic [AW-1:0]   w_right;
    logic [AW-1:0]   w_parent;
    logic            w_empty;
    logic            w_full;
    logic            w_up;
    logic            w_pick_r;
    kv_t             w_child;
    logic [AW-1:0]   w_cidx;
    logic            w_swap;

    assign w_left   = AW'(hp_left(32'(r_idx), AW));
    assign w_right  = AW'(hp_right(32'(r_idx), AW));
    assign w_parent = AW'(hp_parent(32'(r_idx), AW));
    assign w_empty  = (r_size == '0);
    assign w_full   = (r_size == AW'(DEPTH));

    // Sift-up: dout holds the parent. Sift-down: dout holds the right child when r_rvalid.
    assign w_up     = better(r_cur, w_dout);
    assign w_pick_r = r_rvalid && better(w_dout, r_lkv);
    assign w_child  = w_pick_r ? w_dout : r_lkv;
    assign w_cidx   = w_pick_r ? w_right : w_left;
    assign w_swap   = better(w_child, r_cur);

    always_comb begin
        w_we      = 1'b0;
        w_ram_idx = r_idx;
        w_din     = r_cur;
        case (r_state)
            ENQ_WR:     w_we = 1'b1;
            ENQ_RDP:    w_ram_idx = w_parent;
            ENQ_CMP:    if (w_up) begin
                            w_we  = 1'b1;
                            w_din = w_dout;
                        end
            ENQ_SWP2:   begin
                            w_we      = 1'b1;
                            w_ram_idx = w_parent;
                        end
            DEQ_RDLAST: w_ram_idx = r_size;
            DEQ_WRROOT: begin
                            w_we      = 1'b1;
                            w_ram_idx = ONE;
                            w_din     = w_dout;
                        end
            RPL_WR:     begin
                            w_we      = 1'b1;
                            w_ram_idx = ONE;
                        end
            HP_RDL:     w_ram_idx = w_left;
            HP_RDR:     w_ram_idx = w_right;
            HP_CMP:     if (w_swap) begin
                            w_we  = 1'b1;
                            w_din = w_child;
                        end
            HP_SWP2:    begin
                            w_we      = 1'b1;
                            w_ram_idx = r_cidx;
                        end
            default:    ;
        endcase
    end

    assign w_addr = CW'(w_ram_idx);

    mem_swsr #(
        .W (KW + VW),
        .D (DEPTH + 1)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_we),
        .i_addr (w_addr),
        .i_din  (w_din),
        .o_dout (w_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_size   <= '0;
            r_idx    <= '0;
            r_cidx   <= '0;
            r_cur    <= '0;
            r_lkv    <= '0;
            r_rvalid <= 1'b0;
            r_head   <= '0;
        end else begin
            // Any write landing on the root is mirrored into the head register.
            if (w_we && w_ram_idx == ONE) r_head <= w_din;
            case (r_state)
                IDLE: begin
                    case (decode_cmd(i_enq, i_deq, w_empty, w_full))
                        CMD_ENQ: begin
                            r_cur   <= '{key: i_kvi_key, val: i_kvi_val};
                            r_idx   <= r_size + ONE;
                            r_state <= ENQ_WR;
                        end
                        CMD_DEQ: r_state <= DEQ_RDLAST;
                        CMD_RPL: begin
                            r_cur   <= '{key: i_kvi_key, val: i_kvi_val};
                            r_state <= RPL_WR;
                        end
                        default: ;
                    endcase
                end
                ENQ_WR: begin
                    r_size  <= r_size + ONE;
                    r_state <= (r_idx == ONE) ? IDLE : ENQ_RDP;
                end
                ENQ_RDP:  r_state <= ENQ_CMP;
                ENQ_CMP:  r_state <= w_up ? ENQ_SWP2 : IDLE;
                ENQ_SWP2: begin
                    r_idx   <= w_parent;
                    r_state <= (w_parent == ONE) ? IDLE : ENQ_RDP;
                end
                DEQ_RDLAST: begin
                    r_size  <= r_size - ONE;
                    r_state <= (r_size == ONE) ? IDLE : DEQ_WRROOT;
                end
                DEQ_WRROOT: begin
                    r_cur   <= w_dout;
                    r_idx   <= ONE;
                    r_state <= HP_RDL;
                end
                RPL_WR: begin
                    r_idx   <= ONE;
                    r_state <= HP_RDL;
                end
                HP_RDL: r_state <= (w_left <= r_size) ? HP_RDR : IDLE;
                HP_RDR: begin
                    r_lkv    <= w_dout;
                    r_rvalid <= (w_right <= r_size);
                    r_state  <= HP_CMP;
                end
                HP_CMP: begin
                    if (w_swap) begin
                        r_cidx  <= w_cidx;
                        r_state <= HP_SWP2;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                HP_SWP2: begin
                    r_idx   <= r_cidx;
                    r_state <= HP_RDL;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_kvo_key   = r_head.key;
    assign o_kvo_val   = r_head.val;
    assign o_kvo_valid = !w_empty;
    assign o_busy      = (r_state != IDLE);
    assign o_full      = w_full;
    assign o_empty     = w_empty;

`ifdef HEAP_PQ_STATS_EN
    logic [CW-1:0] r_peak;

    // Size only grows in ENQ_WR, so tracking the peak there keeps it in step with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_peak <= '0;
        end else if (r_state == ENQ_WR && (r_size + ONE) > {1'b0, r_peak}) begin
            r_peak <= CW'(r_size + ONE);
        end
    end

    assign o_count = r_size[CW-1:0];
    assign o_peak  = r_peak;
`endif

endmodule

// File: tb/tb_heap_pq_gen.sv
// Bench for heap_pq_gen: a min-heap and a max-heap instance share one command stream and are
// checked against a multiset model; directed cases pin literal heads, then random traffic.
module tb_heap_pq_gen;

    localparam int KW    = 16;
    localparam int VW    = 16;
    localparam int DEPTH = 15;
    localparam int L     = $clog2(DEPTH + 1);
    localparam int BOUND = 2 + 5 * (L - 1);
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        int k;
        int v;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enq = 1'b0;
    logic deq = 1'b0;
    logic [KW-1:0] kkey = '0;
    logic [VW-1:0] kval = '0;

    logic [KW-1:0] key0, key1;
    logic [VW-1:0] val0, val1;
    logic valid0, valid1, busy0, busy1, full0, full1, empty0, empty1;
`ifdef HEAP_PQ_STATS_EN
    logic [CW-1:0] cnt0, cnt1, pk0, pk1;
`endif

    int n_chk = 0;
    int n_err = 0;
    item_t mq[2][$];
    int mpeak = 0;
    int bc0 = 0;
    int bc1 = 0;

    always #5 clk = ~clk;

    heap_pq_gen #(.KW(KW), .VW(VW), .DEPTH(DEPTH), .MIN_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .i_enq(enq), .i_deq(deq),
        .i_kvi_key(kkey), .i_kvi_val(kval),
        .o_kvo_key(key0), .o_kvo_val(val0), .o_kvo_valid(valid0),
        .o_busy(busy0), .o_full(full0), .o_empty(empty0)
`ifdef HEAP_PQ_STATS_EN
       ,.o_count(cnt0), .o_peak(pk0)
`endif
    );

    heap_pq_gen #(.KW(KW), .VW(VW), .DEPTH(DEPTH), .MIN_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .i_enq(enq), .i_deq(deq),
        .i_kvi_key(kkey), .i_kvi_val(kval),
        .o_kvo_key(key1), .o_kvo_val(val1), .o_kvo_valid(valid1),
        .o_busy(busy1), .o_full(full1), .o_empty(empty1)
`ifdef HEAP_PQ_STATS_EN
       ,.o_count(cnt1), .o_peak(pk1)
`endif
    );

    // Instance 0 orders smallest-first, instance 1 largest-first; first occurrence wins a tie.
    function automatic int best_idx(input int m);
        int b;
        b = 0;
        for (int i = 1; i < mq[m].size(); i++) begin
            if (m == 0 ? (mq[m][i].k < mq[m][b].k) : (mq[m][i].k > mq[m][b].k)) b = i;
        end
        return b;
    endfunction

    // The value at the head is only predictable when every entry sharing the best key agrees on it.
    function automatic bit tie_ok(input int m, input int b);
        for (int i = 0; i < mq[m].size(); i++) begin
            if (mq[m][i].k == mq[m][b].k && mq[m][i].v != mq[m][b].v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_apply(input logic e, input logic d, input int k, input int v);
        int sz;
        sz = mq[0].size();
        for (int m = 0; m < 2; m++) begin
            if (e && d && sz != 0) begin
                mq[m].delete(best_idx(m));
                mq[m].push_back('{k: k, v: v});
            end else if (e && sz != DEPTH) begin
                mq[m].push_back('{k: k, v: v});
            end else if (d && sz != 0) begin
                mq[m].delete(best_idx(m));
            end
        end
        if (mq[0].size() > mpeak) mpeak = mq[0].size();
    endtask

    task automatic model_clear();
        mq[0].delete();
        mq[1].delete();
        mpeak = 0;
    endtask

    task automatic check_inst(input int m, input logic [KW-1:0] k, input logic [VW-1:0] v,
                              input logic vld, input logic emp, input logic ful);
        int sz;
        int b;
        int ek;
        int ev;
        bit bad;
        sz  = mq[m].size();
        ek  = 0;
        ev  = 0;
        bad = 1'b0;
        if (vld != (sz != 0) || emp != (sz == 0) || ful != (sz == DEPTH)) bad = 1'b1;
        if (sz != 0) begin
            b  = best_idx(m);
            ek = mq[m][b].k;
            ev = mq[m][b].v;
            if (int'(k) != ek) bad = 1'b1;
            if (tie_ok(m, b) && int'(v) != ev) bad = 1'b1;
        end
        n_chk++;
        if (bad) begin
            n_err++;
            $display("FAIL head%0d: got valid=%b empty=%b full=%b key=%0d val=%0d, want size=%0d key=%0d val=%0d",
                     m, vld, emp, ful, k, v, sz, ek, ev);
        end
    endtask

    task automatic lat_check(input int m, input int cycles);
        n_chk++;
        if (cycles > BOUND) begin
            n_err++;
            $display("FAIL latency%0d: busy for %0d cycles, allowed %0d", m, cycles, BOUND);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            bc0 = 0;
            bc1 = 0;
        end else begin
            if (busy0) bc0++;
            else begin
                if (bc0 > 0) lat_check(0, bc0);
                bc0 = 0;
            end
            if (busy1) bc1++;
            else begin
                if (bc1 > 0) lat_check(1, bc1);
                bc1 = 0;
            end
            if (!busy0 && !busy1) begin
                check_inst(0, key0, val0, valid0, empty0, full0);
                check_inst(1, key1, val1, valid1, empty1, full1);
`ifdef HEAP_PQ_STATS_EN
                n_chk++;
                if (int'(cnt0) != mq[0].size() || int'(pk0) != mpeak ||
                    int'(cnt1) != mq[1].size() || int'(pk1) != mpeak) begin
                    n_err++;
                    $display("FAIL stats: got count=%0d/%0d peak=%0d/%0d, want count=%0d peak=%0d",
                             cnt0, cnt1, pk0, pk1, mq[0].size(), mpeak);
                end
`endif
            end
        end
    end

    task automatic expect_eq(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // All drivers are entered at posedge+#1 and return at posedge+#1.
    task automatic wait_idle();
        int w;
        w = 0;
        while ((busy0 || busy1) && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 200) begin
            n_chk++;
            n_err++;
            $display("FAIL idle_wait: busy=%b%b after %0d cycles, want 00", busy0, busy1, w);
        end
    endtask

    task automatic cmd(input logic e, input logic d, input int k, input int v);
        wait_idle();
        enq  = e;
        deq  = d;
        kkey = KW'(k);
        kval = VW'(v);
        @(posedge clk);
        #1;
        enq = 1'b0;
        deq = 1'b0;
        model_apply(e, d, k, v);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mq[0].size() > 0 && n < 2 * DEPTH) begin
            cmd(1'b0, 1'b1, 0, 0);
            n++;
        end
        wait_idle();
    endtask

    initial begin
        int exp_deq[4];
        int r;
        int k;
        exp_deq = '{1, 3, 5, 8};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        expect_eq("rst_empty", int'(empty0), 1);
        expect_eq("rst_valid", int'(valid0), 0);
        expect_eq("rst_busy", int'(busy0), 0);
        expect_eq("rst_full", int'(full0), 0);
        expect_eq("rst_key", int'(key0), 0);
        expect_eq("rst_val", int'(val0), 0);

        // Basic insert/remove order; enq into empty is busy exactly one cycle.
        cmd(1'b1, 1'b0, 5, 50);
        expect_eq("enq_empty_busy", int'(busy0), 1);
        @(posedge clk);
        #1;
        expect_eq("enq_empty_done", int'(busy0), 0);
        expect_eq("enq_empty_head", int'(key0), 5);
        cmd(1'b1, 1'b0, 3, 30);
        cmd(1'b1, 1'b0, 8, 80);
        cmd(1'b1, 1'b0, 1, 10);
        wait_idle();
        expect_eq("t1_head_key", int'(key0), 1);
        expect_eq("t1_head_val", int'(val0), 10);
        expect_eq("t1_max_head", int'(key1), 8);
        for (int i = 0; i < 4; i++) begin
            wait_idle();
            expect_eq("t1_deq_order", int'(key0), exp_deq[i]);
            cmd(1'b0, 1'b1, 0, 0);
        end
        wait_idle();
        expect_eq("t1_empty", int'(empty0), 1);
        drain();

        // Fill to capacity; an extra enq is ignored.
        for (int i = DEPTH; i >= 1; i--) cmd(1'b1, 1'b0, i, i + 100);
        wait_idle();
        expect_eq("t2_full", int'(full0), 1);
        cmd(1'b1, 1'b0, 99, 99);
        expect_eq("t2_enq_full_busy", int'(busy0), 0);
`ifdef HEAP_PQ_STATS_EN
        expect_eq("t2_count", int'(cnt0), 15);
`endif
        expect_eq("t2_min_head", int'(key0), 1);
        expect_eq("t2_max_head", int'(key1), 15);
        cmd(1'b0, 1'b1, 0, 0);
        wait_idle();
        expect_eq("t2_min_after_deq", int'(key0), 2);
        expect_eq("t2_max_after_deq", int'(key1), 14);
        drain();

        // Replace: removes the current head and inserts the new item, size unchanged.
        cmd(1'b1, 1'b0, 2, 20);
        cmd(1'b1, 1'b0, 4, 40);
        cmd(1'b1, 1'b0, 6, 60);
        wait_idle();
        expect_eq("t3_head_before", int'(key0), 2);
        cmd(1'b1, 1'b1, 5, 50);
        wait_idle();
        expect_eq("t3_rpl_min_head", int'(key0), 4);
        expect_eq("t3_rpl_max_head", int'(key1), 5);
        for (int i = 10; i <= 21; i++) cmd(1'b1, 1'b0, i, i);
        wait_idle();
        expect_eq("t3_full", int'(full0), 1);
        cmd(1'b1, 1'b1, 30, 300);
        wait_idle();
        expect_eq("t3_rpl_full_still_full", int'(full0), 1);
        expect_eq("t3_rpl_full_min_head", int'(key0), 5);
        expect_eq("t3_rpl_full_max_head", int'(key1), 30);
        drain();

        // Max ordering, and equal keys never swap.
        cmd(1'b1, 1'b0, 7, 70);
        cmd(1'b1, 1'b0, 9, 90);
        cmd(1'b1, 1'b0, 2, 20);
        wait_idle();
        expect_eq("t4_max_head", int'(key1), 9);
        cmd(1'b0, 1'b1, 0, 0);
        wait_idle();
        expect_eq("t4_max_after_deq", int'(key1), 7);
        drain();
        cmd(1'b1, 1'b0, 4, 'h111);
        cmd(1'b1, 1'b0, 4, 'h222);
        wait_idle();
        expect_eq("t4_tie_max_val", int'(val1), 'h111);
        expect_eq("t4_tie_min_val", int'(val0), 'h111);
        cmd(1'b0, 1'b1, 0, 0);
        wait_idle();
        expect_eq("t4_tie_max_second", int'(val1), 'h222);
        expect_eq("t4_tie_min_second", int'(val0), 'h222);
        drain();

        // Edge cases on an empty queue.
        cmd(1'b0, 1'b1, 0, 0);
        expect_eq("t5_deq_empty_busy", int'(busy0), 0);
        expect_eq("t5_deq_empty_empty", int'(empty0), 1);
        cmd(1'b1, 1'b1, 42, 420);
        wait_idle();
        expect_eq("t5_enqdeq_empty_key", int'(key0), 42);
        expect_eq("t5_enqdeq_empty_valid", int'(valid0), 1);
        drain();

        // Reset while a sift-down is in flight.
        for (int i = DEPTH; i >= 1; i--) cmd(1'b1, 1'b0, i, i);
        cmd(1'b0, 1'b1, 0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        expect_eq("t5_mid_sift_busy", int'(busy0), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_eq("t5_rst_empty", int'(empty0), 1);
        expect_eq("t5_rst_valid", int'(valid0), 0);
        expect_eq("t5_rst_busy", int'(busy0), 0);
        rst = 1'b0;
        model_clear();

        // Random traffic against the model; value is a function of key so ties stay checkable.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            k = $urandom_range(0, 63);
            if (r < 50)      cmd(1'b1, 1'b0, k, k * 7 + 3);
            else if (r < 80) cmd(1'b0, 1'b1, k, k * 7 + 3);
            else if (r < 90) cmd(1'b1, 1'b1, k, k * 7 + 3);
            else             cmd(1'b0, 1'b0, k, k * 7 + 3);
        end
        wait_idle();
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
